// File: rtl/debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw pushbutton into a clean level plus one-cycle press/release pulses.
//
//   state        | meaning
//   IDLE         | released and stable, level 0
//   PRESS_WAIT   | input high, counting stable cycles, level 0
//   PRESSED      | pressed and stable, level 1
//   RELEASE_WAIT | input low, counting stable cycles, level 1
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync_btn (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (btn_i),
    .q_o  (btn_s)
  );

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // The terminal count always forces a state exit, so cnt_q never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (btn_s) begin
            state_q <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        PRESSED: begin
          cnt_q <= '0;
          if (!btn_s) begin
            state_q <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level_o     = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_button_debouncer;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic btn_i = 1'b0;
  logic btn_level_o;
  logic press_pulse_o;
  logic release_pulse_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       btn;
    logic       rst;
    logic [2:0] exp;   // {level, press, release} after the edge
  } vec_t;

  vec_t vecs[$];

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .btn_i          (btn_i),
    .btn_level_o    (btn_level_o),
    .press_pulse_o  (press_pulse_o),
    .release_pulse_o(release_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic add_n(input int n, input logic b, input logic r, input logic [2:0] e);
    vec_t v;
    v.btn = b;
    v.rst = r;
    v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic step(input logic b, input logic r);
    btn_i = b;
    rst_i = r;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got {lvl,prs,rel}=%b expected %b", name, idx, act, exp);
    end
  endtask

  function automatic logic [2:0] outs();
    return {btn_level_o, press_pulse_o, release_pulse_o};
  endfunction

  int n_press;
  int n_rel;

  initial begin
    // test 1: reset held with button down, then press debounced after full latency
    add_n(3, 1'b1, 1'b1, 3'b000);
    add_n(6, 1'b1, 1'b0, 3'b000);
    add_n(1, 1'b1, 1'b0, 3'b110);
    add_n(3, 1'b1, 1'b0, 3'b100);
    add_n(6, 1'b0, 1'b0, 3'b100);
    add_n(1, 1'b0, 1'b0, 3'b001);
    add_n(3, 1'b0, 1'b0, 3'b000);
    // test 2: clean press held 20 cycles, clean release
    add_n(6,  1'b1, 1'b0, 3'b000);
    add_n(1,  1'b1, 1'b0, 3'b110);
    add_n(13, 1'b1, 1'b0, 3'b100);
    add_n(6,  1'b0, 1'b0, 3'b100);
    add_n(1,  1'b0, 1'b0, 3'b001);
    add_n(4,  1'b0, 1'b0, 3'b000);
    // test 3: bounce 1,0,1,0,1 then hold
    add_n(1, 1'b1, 1'b0, 3'b000);
    add_n(1, 1'b0, 1'b0, 3'b000);
    add_n(1, 1'b1, 1'b0, 3'b000);
    add_n(1, 1'b0, 1'b0, 3'b000);
    add_n(6, 1'b1, 1'b0, 3'b000);
    add_n(1, 1'b1, 1'b0, 3'b110);
    add_n(2, 1'b1, 1'b0, 3'b100);
    add_n(6, 1'b0, 1'b0, 3'b100);
    add_n(1, 1'b0, 1'b0, 3'b001);
    add_n(3, 1'b0, 1'b0, 3'b000);
    // test 4: 3-cycle glitch never accepted
    add_n(3, 1'b1, 1'b0, 3'b000);
    add_n(8, 1'b0, 1'b0, 3'b000);

    @(negedge clk_i);
    foreach (vecs[i]) begin
      step(vecs[i].btn, vecs[i].rst);
      check("table", i, outs(), vecs[i].exp);
    end

    // test 5: reset pulse while PRESSED, button still held
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
    check("t5_pressed", 0, outs(), 3'b100);
    step(1'b1, 1'b1);
    check("t5_reset", 0, outs(), 3'b000);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0);
      check("t5_repress", k, outs(), {(k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, 1'b0});
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      check("t5_release", k, outs(), {(k < 6) ? 1'b1 : 1'b0, 1'b0, (k == 6) ? 1'b1 : 1'b0});
    end

    // test 6: long hold gives a single press and no release until let go
    n_press = 0;
    n_rel   = 0;
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, 1'b0);
      if (press_pulse_o) n_press++;
      if (release_pulse_o) n_rel++;
    end
    check("t6_press_count", n_press, 3'(n_press), 3'd1);
    check("t6_no_release", n_rel, 3'(n_rel), 3'd0);
    check("t6_level_held", 0, outs(), 3'b100);
    n_rel = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0);
      if (release_pulse_o) n_rel++;
      if (press_pulse_o) n_press++;
    end
    check("t6_release_count", n_rel, 3'(n_rel), 3'd1);
    check("t6_no_extra_press", n_press, 3'(n_press), 3'd1);
    check("t6_idle", 0, outs(), 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
